// File: rtl/serdes_mux_pkg.sv
// Shared sizing for the SerDes capacitor-bank routing stage.
// RANK_W must be able to hold a count of every slot, hence CAPACITOR_NUM+1.
package serdes_mux_pkg;

  localparam int WIDTH         = 2;
  localparam int CHANNEL_NUM   = 70;
  localparam int CAPACITOR_NUM = 128;
  localparam int RANK_W        = $clog2(CAPACITOR_NUM + 1);

  localparam int DATA_W = WIDTH * CHANNEL_NUM;
  localparam int OUT_W  = WIDTH * CAPACITOR_NUM;

endpackage

// File: rtl/serdes_mux_top_slot_rank.sv
// Prefix popcount of the slot-enable bitmap: rank[i] = number of enabled slots below i.
// Implemented as a ripple of small adders; depth is fine for this bank size.
module slot_rank
  import serdes_mux_pkg::*;
(
  input  logic [CAPACITOR_NUM-1:0]        sw,
  output logic [CAPACITOR_NUM*RANK_W-1:0] rank
);

  logic [RANK_W-1:0] acc;

  // NOTE: acc is a scratch variable inside combinational logic, so it is updated
  // with blocking assignments; each slot sees the count before its own bit is added.
  always_comb begin
    rank = '0;
    acc  = '0;
    for (int i = 0; i < CAPACITOR_NUM; i++) begin
      rank[RANK_W*i +: RANK_W] = acc;
      acc = acc + RANK_W'(sw[i]);
    end
  end

endmodule

// File: rtl/serdes_mux_top.sv
// Capacitor-bank routing: the k-th enabled slot (from LSB) carries channel k,
// unselected or overflow slots are zero. One registered output stage.
module serdes_mux_top
  import serdes_mux_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [CAPACITOR_NUM-1:0] sw,
  output logic [OUT_W-1:0]         data_out_FF
);

  logic [CAPACITOR_NUM*RANK_W-1:0] rank;
  logic [OUT_W-1:0]                slot_next;

  slot_rank u_slot_rank (
    .sw   (sw),
    .rank (rank)
  );

  for (genvar i = 0; i < CAPACITOR_NUM; i++) begin : g_slot
    logic [RANK_W-1:0] r;
    logic [WIDTH-1:0]  d;

    assign r = rank[RANK_W*i +: RANK_W];

    // Slots whose rank runs past the last channel stay zero.
    always_comb begin
      d = '0;
      if (sw[i] && (r < RANK_W'(CHANNEL_NUM))) begin
        for (int c = 0; c < CHANNEL_NUM; c++) begin
          if (r == RANK_W'(c)) d = data_in[WIDTH*c +: WIDTH];
        end
      end
    end

    assign slot_next[WIDTH*i +: WIDTH] = d;
  end

  // rst_n is active-high despite its name; the clear is asynchronous.
  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) data_out_FF <= '0;
    else       data_out_FF <= slot_next;
  end

endmodule

// File: tb/tb_serdes_mux_top.sv
// Randomised scoreboard bench for serdes_mux_top against a slot-walking reference model.
module tb_serdes_mux_top;
  import serdes_mux_pkg::*;

  typedef logic [OUT_W-1:0]         out_t;
  typedef logic [DATA_W-1:0]        data_t;
  typedef logic [CAPACITOR_NUM-1:0] sw_t;

  logic  clk = 1'b0;
  logic  rst_n;
  data_t data_in;
  sw_t   sw;
  out_t  data_out_FF;

  out_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "init";

  serdes_mux_top dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .sw          (sw),
    .data_out_FF (data_out_FF)
  );

  always #5 clk = ~clk;

  // Walk the slots; every enabled slot consumes the next channel while any remain.
  function automatic out_t model(data_t d, sw_t s);
    out_t o = '0;
    int   k = 0;
    for (int i = 0; i < CAPACITOR_NUM; i++) begin
      if (s[i]) begin
        if (k < CHANNEL_NUM) o[WIDTH*i +: WIDTH] = d[WIDTH*k +: WIDTH];
        k++;
      end
    end
    return o;
  endfunction

  function automatic data_t rand_data();
    logic [159:0] t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DATA_W-1:0];
  endfunction

  function automatic sw_t rand_sw();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(string name, out_t got, out_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Inputs change on the falling edge; the expected capture of the next rising edge is queued.
  task automatic drive(data_t d, sw_t s, logic r);
    @(negedge clk);
    rst_n   = r;
    data_in = d;
    sw      = s;
    exp_q.push_back(r ? out_t'('0) : model(d, s));
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check(phase, data_out_FF, exp_q.pop_front());
    end
  end

  initial begin : stimulus
    data_t d;
    data_t lower;
    sw_t   a, b, s;

    data_in = '0;
    sw      = '0;
    rst_n   = 1'b0;
    #1 rst_n = 1'b1;
    #1 check("reset_async", data_out_FF, '0);

    phase = "reset_hold";
    repeat (5) drive(rand_data(), rand_sw(), 1'b1);

    phase = "lower_bank";
    lower = {64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 12'hFED};
    repeat (2) drive(lower, {58'b0, {70{1'b1}}}, 1'b0);

    phase = "upper_bank";
    repeat (2) drive(lower, {{70{1'b1}}, 58'b0}, 1'b0);

    phase = "rotate";
    d = rand_data();
    s = rand_sw();
    for (int n = 0; n < CHANNEL_NUM + 1; n++) begin
      drive(d, s, 1'b0);
      d = {d[WIDTH-1:0], d[DATA_W-1:WIDTH]};
    end

    phase = "sparse";
    repeat (3) drive(rand_data(), {32{4'h5}}, 1'b0);

    phase = "all_ones";
    repeat (3) drive(rand_data(), '1, 1'b0);

    phase = "all_zero";
    drive(rand_data(), '0, 1'b0);

    phase = "random";
    for (int n = 0; n < 40; n++) begin
      a = rand_sw();
      b = rand_sw();
      case (n % 4)
        0:       s = a & b;
        1:       s = a | b;
        2:       s = a;
        default: s = sw_t'(1) << $urandom_range(CAPACITOR_NUM - 1);
      endcase
      drive(rand_data(), s, 1'b0);
    end

    phase = "async_mid";
    drive(rand_data(), '1, 1'b0);
    drive(rand_data(), '1, 1'b0);
    #2 rst_n = 1'b1;
    #1 check("async_clear", data_out_FF, '0);
    rst_n = 1'b0;
    phase = "resume";
    repeat (3) drive(rand_data(), rand_sw(), 1'b0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
